// File: rtl/ball_projectile.sv
// Single ball slot: launches on fire, steps STEP px per frame tick, retires on wall, hit or timeout.
// Optional `BALL_LIFETIME_EN limits flight to LIFETIME frame ticks.
module ball_projectile #(
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 639,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 479,
  parameter int STEP     = 4,
  parameter int LIFETIME = 90
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [3:0] direction,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  logic       hit,
  output logic       done,
  output logic       active,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y
);
  typedef enum logic [1:0] {S_IDLE, S_FLY, S_RETIRE} state_t;
  typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_RIGHT, DIR_LEFT} dir_t;

  localparam logic [10:0] X_LO   = 11'(X_MIN + STEP);
  localparam logic [10:0] X_HI   = 11'(X_MAX);
  localparam logic [10:0] Y_LO   = 11'(Y_MIN + STEP);
  localparam logic [10:0] Y_HI   = 11'(Y_MAX);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [9:0]  STEP_P = 10'(STEP);

  if (STEP < 1 || STEP > 15) begin : g_bad_step
    $error("ball_projectile: STEP must be 1..15");
  end
  if (LIFETIME < 1 || LIFETIME > 255) begin : g_bad_lifetime
    $error("ball_projectile: LIFETIME must be 1..255");
  end

  state_t     state;
  dir_t       dir_q;
  dir_t       dir_in;
  logic       frame_meta, frame_sync, frame_prev, frame_armed;
  logic [1:0] sync_fill;
  logic       tick;
  logic       at_wall;
  logic       life_end;
  logic [9:0] next_x, next_y;

  // Edges are only honoured once a real low sample has passed the synchronizer,
  // so frame_clk already high when reset releases cannot produce a tick.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_meta  <= 1'b0;
      frame_sync  <= 1'b0;
      frame_prev  <= 1'b0;
      frame_armed <= 1'b0;
      sync_fill   <= 2'b00;
    end else begin
      frame_meta <= frame_clk;
      frame_sync <= frame_meta;
      frame_prev <= frame_sync;
      sync_fill  <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && !frame_sync) frame_armed <= 1'b1;
    end
  end

  assign tick = frame_armed && frame_sync && !frame_prev;

  // Multi-hot direction resolves right > left > down > up.
  always_comb begin
    if      (direction[2]) dir_in = DIR_RIGHT;
    else if (direction[3]) dir_in = DIR_LEFT;
    else if (direction[1]) dir_in = DIR_DOWN;
    else if (direction[0]) dir_in = DIR_UP;
    else                   dir_in = DIR_NONE;
  end

  // NOTE: defaults first so no path through the block leaves an output unassigned (no latch).
  always_comb begin
    next_x  = ball_x;
    next_y  = ball_y;
    at_wall = 1'b0;
    case (dir_q)
      DIR_UP:    if ({1'b0, ball_y} < Y_LO)          at_wall = 1'b1; else next_y = ball_y - STEP_P;
      DIR_DOWN:  if ({1'b0, ball_y} + STEP_W > Y_HI) at_wall = 1'b1; else next_y = ball_y + STEP_P;
      DIR_LEFT:  if ({1'b0, ball_x} < X_LO)          at_wall = 1'b1; else next_x = ball_x - STEP_P;
      DIR_RIGHT: if ({1'b0, ball_x} + STEP_W > X_HI) at_wall = 1'b1; else next_x = ball_x + STEP_P;
      default:   at_wall = 1'b0;
    endcase
  end

`ifdef BALL_LIFETIME_EN
  logic [7:0] life_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                                life_cnt <= 8'd0;
    else if (state == S_IDLE)                 life_cnt <= 8'd0;
    else if (state == S_FLY && tick && !hit)  life_cnt <= life_cnt + 8'd1;
  end

  assign life_end = (life_cnt == 8'(LIFETIME - 1));
`else
  assign life_end = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= S_IDLE;
      done   <= 1'b1;
      active <= 1'b0;
      ball_x <= 10'd0;
      ball_y <= 10'd0;
      dir_q  <= DIR_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (fire && dir_in != DIR_NONE) begin
            ball_x <= spawn_x;
            ball_y <= spawn_y;
            dir_q  <= dir_in;
            state  <= S_FLY;
            done   <= 1'b0;
            active <= 1'b1;
          end
        end
        S_FLY: begin
          // A hit wins over a same-cycle tick: the ball stops where it was struck.
          if (hit || (tick && at_wall)) begin
            state  <= S_RETIRE;
            active <= 1'b0;
          end else if (tick) begin
            ball_x <= next_x;
            ball_y <= next_y;
            if (life_end) begin
              state  <= S_RETIRE;
              active <= 1'b0;
            end
          end
        end
        S_RETIRE: begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        default: begin
          state  <= S_IDLE;
          done   <= 1'b1;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_projectile.sv
// Directed plus randomized checks of ball_projectile against a flight-level arithmetic model.
module tb_ball_projectile;
  localparam int STEP  = 4;
  localparam int LIFE  = 5;
  localparam int X_MAX = 639;
  localparam int Y_MAX = 479;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       fire;
  logic [3:0] direction;
  logic [9:0] spawn_x, spawn_y;
  logic       hit;
  logic       done, active;
  logic [9:0] ball_x, ball_y;

  int vectors     = 0;
  int miscompares = 0;

  ball_projectile #(.STEP(STEP), .LIFETIME(LIFE)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .fire      (fire),
    .direction (direction),
    .spawn_x   (spawn_x),
    .spawn_y   (spawn_y),
    .hit       (hit),
    .done      (done),
    .active    (active),
    .ball_x    (ball_x),
    .ball_y    (ball_y)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic launch(input logic [3:0] d, input int x, input int y);
    fire      = 1'b1;
    direction = d;
    spawn_x   = 10'(x);
    spawn_y   = 10'(y);
    cycles(1);
    fire      = 1'b0;
    direction = 4'b0000;
  endtask

  // Tick is taken on the third rising Clk after frame_clk rises.
  task automatic frame_rise();
    frame_clk = 1'b1;
    cycles(3);
  endtask

  task automatic frame_fall();
    frame_clk = 1'b0;
    cycles(3);
  endtask

  task automatic frame();
    frame_rise();
    frame_fall();
  endtask

  task automatic clear_by_hit(input string tag);
    hit = 1'b1;
    cycles(1);
    hit = 1'b0;
    check({tag, "_hit_active"}, active, 0);
    cycles(1);
    check({tag, "_hit_done"}, done, 1);
  endtask

  logic [3:0] d;
  int x, y, n, dx, dy, wall, moves, ex, ey;
  bit retired;

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; fire = 1'b0; hit = 1'b0;
    direction = 4'b0000; spawn_x = 10'd0; spawn_y = 10'd0;
    cycles(2);
    Reset = 1'b0;
    cycles(4);

    check("rst_done", done, 1);
    check("rst_active", active, 0);
    check("rst_x", ball_x, 0);
    check("rst_y", ball_y, 0);

    // Rightward flight, three frames.
    launch(4'b0100, 100, 200);
    check("launch_active", active, 1);
    check("launch_done", done, 0);
    check("launch_x", ball_x, 100);
    check("launch_y", ball_y, 200);
    repeat (3) frame();
    check("right3_x", ball_x, 112);
    check("right3_y", ball_y, 200);
    check("right3_done", done, 0);
    check("right3_active", active, 1);

    // Reset mid-flight acts immediately; a high frame_clk at release gives no tick.
    Reset = 1'b1;
    #1;
    check("midrst_done", done, 1);
    check("midrst_active", active, 0);
    check("midrst_x", ball_x, 0);
    check("midrst_y", ball_y, 0);
    frame_clk = 1'b1;
    cycles(2);
    Reset = 1'b0;
    cycles(1);
    launch(4'b0100, 300, 100);
    cycles(4);
    check("no_residual_tick_x", ball_x, 300);
    frame_fall();
    frame_rise();
    check("first_real_tick_x", ball_x, 304);
    frame_fall();
    clear_by_hit("postrst");

    // Upward flight into the top wall.
    launch(4'b0001, 50, 6);
    frame();
    check("up1_y", ball_y, 2);
    check("up1_active", active, 1);
    frame_rise();
    check("upwall_active", active, 0);
    check("upwall_done", done, 0);
    check("upwall_y", ball_y, 2);
    cycles(1);
    check("upwall_done_late", done, 1);
    check("upwall_y_held", ball_y, 2);
    check("upwall_x_held", ball_x, 50);
    frame_fall();

    // Hit in the same cycle as a tick: no move.
    launch(4'b0100, 20, 20);
    frame();
    check("pre_hit_x", ball_x, 24);
    frame_clk = 1'b1;
    cycles(2);
    hit = 1'b1;
    cycles(1);
    hit = 1'b0;
    check("hittick_x", ball_x, 24);
    check("hittick_active", active, 0);
    check("hittick_done", done, 0);
    cycles(1);
    check("hittick_done_late", done, 1);
    check("hittick_x_held", ball_x, 24);
    frame_fall();

    // Multi-hot direction, no retrigger in flight, fire with no direction in idle.
    launch(4'b0101, 200, 100);
    frame();
    check("prio_x", ball_x, 204);
    check("prio_y", ball_y, 100);
    launch(4'b1000, 7, 7);
    check("refire_x", ball_x, 204);
    check("refire_y", ball_y, 100);
    check("refire_active", active, 1);
    check("refire_done", done, 0);
    frame();
    check("refire_next_x", ball_x, 208);
    clear_by_hit("prio");
    cycles(1);
    launch(4'b0000, 1, 1);
    check("nodir_done", done, 1);
    check("nodir_active", active, 0);
    check("nodir_x", ball_x, 208);

    // Lifetime: down from y=10.
    launch(4'b0010, 100, 10);
    repeat (4) frame();
    check("life4_y", ball_y, 26);
    check("life4_active", active, 1);
    frame_rise();
    check("life5_y", ball_y, 30);
`ifdef BALL_LIFETIME_EN
    check("life5_active", active, 0);
    cycles(1);
    check("life5_done", done, 1);
    frame_fall();
`else
    check("life5_active", active, 1);
    frame_fall();
    frame();
    check("life6_y", ball_y, 34);
    check("life6_active", active, 1);
    clear_by_hit("life");
`endif

    // Randomized flights against a move-count model.
    for (int i = 0; i < 24; i++) begin
      d = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 0) x = $urandom_range(0, X_MAX);
      else if ($urandom_range(0, 1) == 0) x = $urandom_range(0, 12);
      else x = X_MAX - $urandom_range(0, 12);
      if ($urandom_range(0, 1) == 0) y = $urandom_range(0, Y_MAX);
      else if ($urandom_range(0, 1) == 0) y = $urandom_range(0, 12);
      else y = Y_MAX - $urandom_range(0, 12);
      n = $urandom_range(0, 7);

      dx = 0; dy = 0;
      if (d[2])      begin dx = 1;  wall = (X_MAX - x) / STEP; end
      else if (d[3]) begin dx = -1; wall = x / STEP;           end
      else if (d[1]) begin dy = 1;  wall = (Y_MAX - y) / STEP; end
      else           begin dy = -1; wall = y / STEP;           end
      moves   = (n < wall) ? n : wall;
      retired = (n > wall);
`ifdef BALL_LIFETIME_EN
      if (moves > LIFE) moves = LIFE;
      if (n >= LIFE) retired = 1'b1;
`endif
      ex = x + dx * moves * STEP;
      ey = y + dy * moves * STEP;

      launch(d, x, y);
      check("rnd_launch_x", ball_x, 32'(x));
      check("rnd_launch_y", ball_y, 32'(y));
      if ($urandom_range(0, 1) == 1) launch(4'($urandom_range(1, 15)), $urandom_range(0, X_MAX), $urandom_range(0, Y_MAX));
      repeat (n) frame();
      check("rnd_x", ball_x, 32'(ex));
      check("rnd_y", ball_y, 32'(ey));
      check("rnd_active", active, retired ? 0 : 1);
      check("rnd_done", done, retired ? 1 : 0);
      if (!retired) clear_by_hit("rnd");
      cycles(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
